regfile_2r1w_sb: RTL and testbench

//   Parametrised 2-read/1-write register file with a per-entry busy scoreboard.

---
 rtl/regfile_2r1w_sb.sv | 101 ++++++++++
 tb/tb_regfile_2r1w_sb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: 2-read/1-write register file with per-entry busy scoreboard,
// registered read ports with write forwarding, and a read stall on busy sources.
// Build option: define REGFILE_ZERO_REG_EN to make register 0 a constant-zero register.
module regfile_2r1w_sb #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr0,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  output logic              o_rd_stall,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data0,
  output logic [DATA_W-1:0] o_rd_data1,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rsv_en,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  output logic [DEPTH-1:0]  o_busy
);
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data0_q, rd_data1_q, rd_data0_d, rd_data1_d;
  logic              in0, in1, zero0, zero1, wr_hit0, wr_hit1;
  logic              hazard0, hazard1, accept, wr_ok, rsv_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Address decode, hazard detection and forwarded read values for both ports
  always_comb begin
    in0        = in_range(i_rd_addr0);
    in1        = in_range(i_rd_addr1);
    zero0      = is_zero_reg(i_rd_addr0);
    zero1      = is_zero_reg(i_rd_addr1);
    wr_hit0    = i_wr_en && (i_wr_addr == i_rd_addr0);
    wr_hit1    = i_wr_en && (i_wr_addr == i_rd_addr1);
    hazard0    = in0 && busy_q[i_rd_addr0] && !wr_hit0;
    hazard1    = in1 && busy_q[i_rd_addr1] && !wr_hit1;
    o_rd_stall = i_rd_req && (hazard0 || hazard1);
    accept     = i_rd_req && !o_rd_stall;
    rd_data0_d = (!in0 || zero0) ? '0 : wr_hit0 ? i_wr_data : mem_q[i_rd_addr0];
    rd_data1_d = (!in1 || zero1) ? '0 : wr_hit1 ? i_wr_data : mem_q[i_rd_addr1];
    wr_ok      = i_wr_en && in_range(i_wr_addr) && !is_zero_reg(i_wr_addr);
    rsv_ok     = i_rsv_en && in_range(i_rsv_addr) && !is_zero_reg(i_rsv_addr);
  end

  // Scoreboard update: writeback clears, reservation sets and wins on collision
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) busy_d[i_wr_addr] = 1'b0;
    if (rsv_ok) busy_d[i_rsv_addr] = 1'b1;
  end

  // Register array storage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // Scoreboard and registered read ports; data holds when no read is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data0_q <= '0;
      rd_data1_q <= '0;
    end else begin
      busy_q     <= busy_d;
      rd_valid_q <= accept;
      if (accept) begin
        rd_data0_q <= rd_data0_d;
        rd_data1_q <= rd_data1_d;
      end
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_data0 = rd_data0_q;
  assign o_rd_data1 = rd_data1_q;
  assign o_busy     = busy_q;
endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb_regfile_2r1w_sb: directed vector table, reset corner cases and randomized
// traffic against a behavioural register-file/scoreboard model.
module tb_regfile_2r1w_sb;
  localparam int D  = 24;
  localparam int AW = 5;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  typedef struct {
    logic req; logic [AW-1:0] a0, a1;
    logic we; logic [AW-1:0] wa; logic [31:0] wd;
    logic re; logic [AW-1:0] ra;
    logic st, v; logic [31:0] d0, d1; logic [D-1:0] bz;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rd_req = 0, wr_en = 0, rsv_en = 0;
  logic [AW-1:0] rd_addr0 = 0, rd_addr1 = 0, wr_addr = 0, rsv_addr = 0;
  logic [31:0] wr_data = 0;
  logic rd_stall, rd_valid;
  logic [31:0] rd_data0, rd_data1;
  logic [D-1:0] busy;

  regfile_2r1w_sb #(.DATA_W(32), .DEPTH(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(rd_req), .i_rd_addr0(rd_addr0),
    .i_rd_addr1(rd_addr1), .o_rd_stall(rd_stall), .o_rd_valid(rd_valid),
    .o_rd_data0(rd_data0), .o_rd_data1(rd_data1), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rsv_en(rsv_en),
    .i_rsv_addr(rsv_addr), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic s_stall;
  logic [31:0] mm [D];
  bit mb [D];
  bit m_stall, m_valid;
  logic [31:0] m_d0, m_d1;
  vec_t tv [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [D-1:0] bb(input int i);
    logic [D-1:0] r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(logic req, logic [AW-1:0] a0, a1, logic we, logic [AW-1:0] wa,
                              logic [31:0] wd, logic re, logic [AW-1:0] ra, logic st, v,
                              logic [31:0] d0, d1, logic [D-1:0] bz);
    return '{req, a0, a1, we, wa, wd, re, ra, st, v, d0, d1, bz};
  endfunction

  function automatic logic [D-1:0] model_busy();
    logic [D-1:0] r;
    for (int i = 0; i < D; i++) r[i] = mb[i];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a >= D || (ZR && a == 0)) return 32'd0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return mm[a];
  endfunction

  function automatic bit model_hazard(input int a);
    return a < D && mb[a] && !(wr_en && int'(wr_addr) == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      mm[i] = '0;
      mb[i] = 1'b0;
    end
    m_valid = 0; m_d0 = '0; m_d1 = '0;
  endtask

  task automatic step(input logic req, input logic [AW-1:0] a0, a1, input logic we,
                      input logic [AW-1:0] wa, input logic [31:0] wd, input logic re,
                      input logic [AW-1:0] ra);
    rd_req = req; rd_addr0 = a0; rd_addr1 = a1;
    wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = ra;
    #1;
    s_stall = rd_stall;
    m_stall = req && (model_hazard(int'(a0)) || model_hazard(int'(a1)));
    m_valid = req && !m_stall;
    if (m_valid) begin
      m_d0 = model_read(int'(a0));
      m_d1 = model_read(int'(a1));
    end
    if (we && int'(wa) < D && !(ZR && wa == 0)) begin
      mm[wa] = wd;
      mb[wa] = 1'b0;
    end
    if (re && int'(ra) < D && !(ZR && ra == 0)) mb[ra] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0]  = mk(1, 5, 31, 0, 0, 0, 0, 0, 0, 1, 0, 0, '0);
    tv[1]  = mk(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, '0);
    tv[2]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, '0);
    tv[3]  = mk(1, 7, 7, 1, 7, 32'h1234, 0, 0, 0, 1, 32'h1234, 32'h1234, '0);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 32'h1234, 32'h1234, bb(3));
    tv[5]  = mk(1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 32'h1234, bb(3));
    tv[6]  = mk(1, 0, 3, 1, 3, 32'h55, 0, 0, 0, 1, 0, 32'h55, '0);
    tv[7]  = mk(0, 0, 0, 1, 9, 32'hAA, 1, 9, 0, 0, 0, 32'h55, bb(9));
    tv[8]  = mk(1, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h55, bb(9));
    tv[9]  = mk(1, 2, 9, 0, 0, 0, 0, 0, 1, 0, 0, 32'h55, bb(9));
    tv[10] = mk(0, 0, 0, 1, 9, 32'hBB, 0, 0, 0, 0, 0, 32'h55, '0);
    tv[11] = mk(1, 9, 7, 0, 0, 0, 0, 0, 0, 1, 32'hBB, 32'h1234, '0);
    tv[12] = mk(1, 4, 0, 0, 0, 0, 1, 4, 0, 1, 0, 0, bb(4));
    tv[13] = mk(1, 4, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, bb(4));
    tv[14] = mk(0, 0, 0, 1, 4, 32'h1, 0, 0, 0, 0, 0, 0, '0);
    tv[15] = mk(1, 30, 23, 1, 30, 32'h77, 1, 30, 0, 1, 0, 0, '0);
    tv[16] = mk(1, 30, 9, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBB, '0);
    tv[17] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hBB, ZR ? '0 : bb(0));
    tv[18] = mk(1, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 1, ZR ? 0 : 32'hFFFF, ZR ? 0 : 32'hFFFF, '0);
    tv[19] = mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 1, ZR ? 0 : 32'hFFFF, 32'hDEADBEEF, '0);
    model_reset();
    #12;
    chk("reset valid", {31'd0, rd_valid}, 0);
    chk("reset data0", rd_data0, 0);
    chk("reset data1", rd_data1, 0);
    chk("reset busy", 32'(busy), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(tv[i].req, tv[i].a0, tv[i].a1, tv[i].we, tv[i].wa, tv[i].wd, tv[i].re, tv[i].ra);
      chk($sformatf("vec%0d stall", i), {31'd0, s_stall}, {31'd0, tv[i].st});
      chk($sformatf("vec%0d valid", i), {31'd0, rd_valid}, {31'd0, tv[i].v});
      chk($sformatf("vec%0d data0", i), rd_data0, tv[i].d0);
      chk($sformatf("vec%0d data1", i), rd_data1, tv[i].d1);
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].bz));
    end
    step(1, 5, 7, 0, 0, 0, 1, 6);
    chk("inflight valid", {31'd0, rd_valid}, 1);
    chk("inflight data0", rd_data0, 32'hDEADBEEF);
    chk("inflight busy", 32'(busy), 32'(bb(6)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset valid", {31'd0, rd_valid}, 0);
    chk("midreset data0", rd_data0, 0);
    chk("midreset data1", rd_data1, 0);
    chk("midreset busy", 32'(busy), 0);
    model_reset();
    #3;
    rst_n = 1'b1;
    step(1, 5, 7, 0, 0, 0, 0, 0);
    chk("postreset valid", {31'd0, rd_valid}, 1);
    chk("postreset data0", rd_data0, 0);
    chk("postreset data1", rd_data1, 0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, AW'($urandom_range(0, 25)), AW'($urandom_range(0, 25)),
           $urandom_range(0, 9) < 4, AW'($urandom_range(0, 25)), $urandom,
           $urandom_range(0, 9) < 3, AW'($urandom_range(0, 25)));
      chk("rand stall", {31'd0, s_stall}, {31'd0, m_stall});
      chk("rand valid", {31'd0, rd_valid}, {31'd0, m_valid});
      chk("rand data0", rd_data0, m_d0);
      chk("rand data1", rd_data1, m_d1);
      chk("rand busy", 32'(busy), 32'(model_busy()));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
